// File: rtl/sw_pkg.sv
// Shared types and helpers for the switch egress stage.
package sw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      DROP
   } ing_state_t;

   localparam logic [31:0] DEF_BCAST_ADDR = '1;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sw_port_fifo.sv
// Single egress FIFO: synchronous write, registered pop data with a one-cycle valid pulse.
module sw_port_fifo
   import sw_pkg::*;
#(
   parameter  int W_WIDTH    = 8,
   parameter  int FIFO_DEPTH = 16,
   localparam int LW         = lvl_w(FIFO_DEPTH),
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic [W_WIDTH-1:0] wdata,
   input  logic               rd,
   output logic [W_WIDTH-1:0] rdata,
   output logic               vld,
   output logic               full,
   output logic               empty,
   output logic [LW-1:0]      level
);

   logic [W_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               push;
   logic               pop;

   assign full  = (level == LW'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign push  = wr & ~full;
   assign pop   = rd & ~empty;

   // NOTE: the storage array has no reset; the pointers and level alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
         vld    <= 1'b0;
      end else begin
         vld <= pop;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/sw_port_group.sv
// Multi-port egress stage: header decode, ingress FSM, per-port FIFOs and drop counter.
module sw_port_group
   import sw_pkg::*;
#(
   parameter  int                 NUM_PORTS  = 4,
   parameter  int                 W_WIDTH    = 8,
   parameter  int                 FIFO_DEPTH = 16,
   parameter  logic [W_WIDTH-1:0] BCAST_ADDR = W_WIDTH'(DEF_BCAST_ADDR),
   localparam int                 LW         = lvl_w(FIFO_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sw_en,
   input  logic [W_WIDTH-1:0]             port_data,
   input  logic [NUM_PORTS*W_WIDTH-1:0]   port_addr,
   output logic                           in_rdy,
   input  logic [NUM_PORTS-1:0]           port_rd,
   output logic [NUM_PORTS*W_WIDTH-1:0]   port_out,
   output logic [NUM_PORTS-1:0]           port_vld,
   output logic [NUM_PORTS-1:0]           port_rdy,
   output logic [NUM_PORTS*LW-1:0]        port_level,
   output logic [15:0]                    drop_cnt
);

   ing_state_t           state;
   logic [NUM_PORTS-1:0] hdr_mask;
   logic [NUM_PORTS-1:0] mask_q;
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] wr_vec;
   logic                 accept;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hdr_mask = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         hdr_mask[i] = (port_data == port_addr[i*W_WIDTH +: W_WIDTH]);
      if (port_data == BCAST_ADDR) hdr_mask = '1;
   end

   // A header waits in IDLE until all of its targets have room; broadcast follows the slowest port.
   always_comb begin
      in_rdy = 1'b1;
      case (state)
         IDLE:    in_rdy = ~|(hdr_mask & full);
         PAYLOAD: in_rdy = ~|(mask_q & full);
         default: in_rdy = 1'b1;
      endcase
   end

   assign accept = sw_en & in_rdy;

   always_comb begin
      wr_vec = '0;
      if (accept) begin
         case (state)
            IDLE:    wr_vec = hdr_mask;
            PAYLOAD: wr_vec = mask_q;
            default: wr_vec = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (|hdr_mask) begin
                     mask_q <= hdr_mask;
                     state  <= PAYLOAD;
                  end else begin
                     if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                     state <= DROP;
                  end
               end
            end
            PAYLOAD, DROP: begin
               if (!sw_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      sw_port_fifo #(
         .W_WIDTH    (W_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .wr    (wr_vec[g]),
         .wdata (port_data),
         .rd    (port_rd[g]),
         .rdata (port_out[g*W_WIDTH +: W_WIDTH]),
         .vld   (port_vld[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .level (port_level[g*LW +: LW])
      );
      assign port_rdy[g] = ~empty[g];
   end

endmodule

// File: tb/tb_sw_port_group.sv
// Randomised and directed bench for sw_port_group against a queue-based behavioural model.
module tb_sw_port_group;

   localparam int NP = 4;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int LW = 5;

   typedef logic [7:0] wq_t[$];

   logic            clk = 1'b0;
   logic            rst;
   logic            sw_en;
   logic [W-1:0]    port_data;
   logic [NP*W-1:0] port_addr;
   logic            in_rdy;
   logic [NP-1:0]   port_rd;
   logic [NP*W-1:0] port_out;
   logic [NP-1:0]   port_vld;
   logic [NP-1:0]   port_rdy;
   logic [NP*LW-1:0] port_level;
   logic [15:0]     drop_cnt;

   always #5 clk = ~clk;

   sw_port_group #(.NUM_PORTS(NP), .W_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_en      (sw_en),
      .port_data  (port_data),
      .port_addr  (port_addr),
      .in_rdy     (in_rdy),
      .port_rd    (port_rd),
      .port_out   (port_out),
      .port_vld   (port_vld),
      .port_rdy   (port_rdy),
      .port_level (port_level),
      .drop_cnt   (drop_cnt)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Behavioural model: one queue per port, a frame-in-progress flag and its destination set.
   logic [7:0] mq[NP][$];
   logic [7:0] m_out[NP];
   bit         m_vld[NP];
   int         m_drop;
   bit         m_in_frame;
   bit         m_dropping;
   bit [NP-1:0] m_dest;
   bit         chk_en = 1'b0;

   function automatic bit [NP-1:0] m_targets(input logic [7:0] d);
      bit [NP-1:0] t = '0;
      if (d == 8'hFF) return '1;
      for (int i = 0; i < NP; i++)
         if (d == port_addr[i*W +: W]) t[i] = 1'b1;
      return t;
   endfunction

   function automatic bit m_in_rdy();
      bit [NP-1:0] t;
      if (m_in_frame && m_dropping) return 1'b1;
      t = m_in_frame ? m_dest : m_targets(port_data);
      for (int i = 0; i < NP; i++)
         if (t[i] && mq[i].size() >= D) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_out[i] = '0;
            m_vld[i] = 1'b0;
         end
         m_drop     = 0;
         m_in_frame = 1'b0;
         m_dropping = 1'b0;
         m_dest     = '0;
      end else begin
         bit          acc;
         bit [NP-1:0] t;
         acc = sw_en && m_in_rdy();
         for (int i = 0; i < NP; i++) begin
            if (port_rd[i] && mq[i].size() > 0) begin
               m_out[i] = mq[i].pop_front();
               m_vld[i] = 1'b1;
            end else begin
               m_vld[i] = 1'b0;
            end
         end
         if (!m_in_frame) begin
            if (acc) begin
               t = m_targets(port_data);
               m_in_frame = 1'b1;
               if (t != '0) begin
                  m_dropping = 1'b0;
                  m_dest     = t;
                  for (int i = 0; i < NP; i++) if (t[i]) mq[i].push_back(port_data);
               end else begin
                  m_dropping = 1'b1;
                  if (m_drop < 65535) m_drop++;
               end
            end
         end else if (!sw_en) begin
            m_in_frame = 1'b0;
         end else if (acc && !m_dropping) begin
            for (int i = 0; i < NP; i++) if (m_dest[i]) mq[i].push_back(port_data);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_rdy", in_rdy, m_in_rdy());
         check("drop_cnt", drop_cnt, m_drop);
         for (int i = 0; i < NP; i++) begin
            check($sformatf("level%0d", i), port_level[i*LW +: LW], mq[i].size());
            check($sformatf("rdy%0d", i), port_rdy[i], mq[i].size() != 0);
            check($sformatf("vld%0d", i), port_vld[i], m_vld[i]);
            check($sformatf("out%0d", i), port_out[i*W +: W], m_out[i]);
         end
      end
   end

   bit [NP-1:0] pop_mask = '0;
   int          pop_pct  = 0;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (pop_mask != '0)
            for (int i = 0; i < NP; i++)
               port_rd[i] = pop_mask[i] && ($urandom_range(99) < pop_pct);
      end
   end

   function automatic logic [LW-1:0] lvl(input int i);
      return port_level[i*LW +: LW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [7:0] w);
      bit acc;
      int n = 0;
      sw_en     = 1'b1;
      port_data = w;
      forever begin
         @(negedge clk);
         acc = in_rdy;
         tick();
         if (acc) break;
         n++;
         if (n > 300) begin
            fail("send_word");
            break;
         end
      end
   endtask

   task automatic send_frame(input wq_t f);
      foreach (f[k]) send_word(f[k]);
      sw_en = 1'b0;
      tick();
   endtask

   task automatic pop_one(input int i, input logic [7:0] exp);
      port_rd = NP'(1) << i;
      tick();
      port_rd = '0;
      check($sformatf("pop_vld%0d", i), port_vld[i], 1'b1);
      check($sformatf("pop_out%0d", i), port_out[i*W +: W], exp);
   endtask

   task automatic drain();
      int n = 0;
      pop_mask = '1;
      pop_pct  = 100;
      while (port_rdy != '0 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail("drain");
      pop_mask = '0;
      tick();
      port_rd = '0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      wq_t f;
      logic [7:0] hdr_tab[6];
      hdr_tab[0] = 8'h01; hdr_tab[1] = 8'h02; hdr_tab[2] = 8'h03;
      hdr_tab[3] = 8'h04; hdr_tab[4] = 8'hFF; hdr_tab[5] = 8'h09;

      rst       = 1'b1;
      sw_en     = 1'b0;
      port_data = '0;
      port_rd   = '0;
      port_addr = {8'h04, 8'h03, 8'h02, 8'h01};
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_in_rdy", in_rdy, 1'b1);
      check("rst_port_rdy", port_rdy, 4'h0);
      check("rst_port_vld", port_vld, 4'h0);
      check("rst_port_out", port_out, 32'h0);
      check("rst_drop", drop_cnt, 16'h0);
      rst = 1'b0;
      tick();

      // Unicast to port 1
      f = {8'h02, 8'hAA, 8'hBB};
      send_frame(f);
      check("uni_lvl1", lvl(1), 5'd3);
      check("uni_lvl0", lvl(0), 5'd0);
      check("uni_lvl3", lvl(3), 5'd0);
      pop_one(1, 8'h02);
      pop_one(1, 8'hAA);
      pop_one(1, 8'hBB);
      tick();
      check("uni_empty", port_rdy, 4'h0);

      // Broadcast
      f = {8'hFF, 8'h11};
      send_frame(f);
      for (int i = 0; i < NP; i++) check($sformatf("bc_lvl%0d", i), lvl(i), 5'd2);
      drain();

      // Broadcast stalls on a nearly full port 3
      f = {8'h04};
      for (int k = 1; k < 15; k++) f.push_back(8'(8'h30 + k));
      send_frame(f);
      check("pre_lvl3", lvl(3), 5'd15);
      f = {8'hFF, 8'h11, 8'h22};
      fork
         send_frame(f);
         begin
            repeat (6) tick();
            check("bc_stall_rdy", in_rdy, 1'b0);
            check("bc_stall_lvl3", lvl(3), 5'd16);
            pop_pct  = 100;
            pop_mask = 4'b1000;
         end
      join
      drain();

      // Unmatched frames
      f = {8'h09, 8'h5A, 8'hA5};
      send_frame(f);
      send_frame(f);
      check("drop_two", drop_cnt, 16'd2);
      check("drop_lvls", port_level, 20'h0);
      check("drop_rdy", in_rdy, 1'b1);

      // Fill port 0, then a held header lands after one pop
      f = {8'h01};
      for (int k = 1; k < 16; k++) f.push_back(8'(8'h50 + k));
      send_frame(f);
      check("full_lvl0", lvl(0), 5'd16);
      f = {8'h01};
      fork
         send_frame(f);
         begin
            repeat (3) tick();
            check("full_rdy", in_rdy, 1'b0);
            pop_one(0, 8'h01);
            check("full_after_pop", lvl(0), 5'd15);
         end
      join
      check("full_relanded", lvl(0), 5'd16);
      port_rd = 4'b0100;
      tick();
      port_rd = '0;
      check("empty_pop_vld", port_vld, 4'h0);
      drain();

      // Reset in the middle of a payload
      sw_en = 1'b1;
      port_data = 8'h02; tick();
      port_data = 8'hAA; tick();
      port_data = 8'hBB; tick();
      rst = 1'b1;
      port_data = 8'h03;
      #1;
      check("mid_rst_in_rdy", in_rdy, 1'b1);
      check("mid_rst_lvls", port_level, 20'h0);
      check("mid_rst_drop", drop_cnt, 16'h0);
      check("mid_rst_vld", port_vld, 4'h0);
      tick();
      rst = 1'b0;
      tick();
      port_data = 8'hCC;
      tick();
      sw_en = 1'b0;
      tick();
      check("post_rst_lvl2", lvl(2), 5'd2);
      check("post_rst_lvl1", lvl(1), 5'd0);
      pop_one(2, 8'h03);
      pop_one(2, 8'hCC);

      // Random back-to-back frames with concurrent random pops
      pop_pct  = 60;
      pop_mask = '1;
      repeat (80) begin
         f.delete();
         f.push_back(hdr_tab[$urandom_range(5)]);
         repeat ($urandom_range(4)) f.push_back(8'($urandom_range(8'h10, 8'hF0)));
         send_frame(f);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
